// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divisor helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per oversample tick; 0 flags an unusable parameter set.
    function automatic int calc_tdiv(input longint br, input longint clkf, input longint os);
        if (br <= 0 || os <= 0 || clkf <= 0) begin
            return 0;
        end
        return int'(clkf / (br * os));
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - oversample tick divider with phase realign
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int BR         = 0,
    parameter int CLKF       = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int TDIV = calc_tdiv(BR, CLKF, OVERSAMPLE);
    localparam int CW   = $clog2(TDIV) + 1;
    localparam logic [CW-1:0] TOP = CW'(TDIV - 1);

    if (BR == 0) begin : g_bad_br
        $fatal(1, "uart_tick_gen: BR must be nonzero");
    end else if (CLKF == 0) begin : g_bad_clkf
        $fatal(1, "uart_tick_gen: CLKF must be nonzero");
    end else if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $fatal(1, "uart_tick_gen: OVERSAMPLE must be even and at least 4");
    end else if ((CLKF % (BR * OVERSAMPLE)) != 0 || TDIV < 1) begin : g_bad_div
        $fatal(1, "uart_tick_gen: CLKF/(BR*OVERSAMPLE) must be a whole number >= 1");
    end

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr || cnt_q == TOP) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == TOP);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampling and valid/ready output
module uart_rx
    import uart_pkg::*;
#(
    parameter int BR         = 0,
    parameter int CLKF       = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_END = 3'(DATA_BITS - 1);

    logic            sync1_q;
    logic            rx_s_q;
    rx_state_t       state_q;
    logic [SW-1:0]   scnt_q;
    logic [2:0]      bcnt_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            ferr_q;
    logic            ovr_q;
    logic            tick;
    logic            tick_clr;

    // Restart the divider on the detected start edge so samples land mid-bit.
    assign tick_clr = (state_q == IDLE) && !rx_s_q;

    uart_tick_gen #(
        .BR         (BR),
        .CLKF       (CLKF),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        scnt_q  <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (scnt_q == S_MID) begin
                            scnt_q  <= '0;
                            bcnt_q  <= '0;
                            state_q <= rx_s_q ? IDLE : DATA;
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (scnt_q == S_END) begin
                            scnt_q          <= '0;
                            shift_q[bcnt_q] <= rx_s_q;
                            if (bcnt_q == B_END) begin
                                state_q <= STOP;
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (scnt_q == S_END) begin
                            scnt_q  <= '0;
                            state_q <= IDLE;
                            // A same-edge accept frees the holding slot, so load wins.
                            if (!rx_s_q) begin
                                ferr_q <= 1'b1;
                            end else if (valid_q && !data_ready) begin
                                ovr_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT    = 160;
    localparam int K_LOAD = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       rx         = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    ev_t        exp_q[$];
    bit         holding = 1'b0;
    bit         prev_dv = 1'b0;
    bit         prev_acc = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         dv_hi_cnt = 0;
    int         last_load_cyc = 0;

    uart_rx #(
        .BR         (115200),
        .CLKF       (18432000),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic got_event(input int kind, input logic [7:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d byte %0h expected no event", kind, b);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        if (kind == K_LOAD && e.kind == K_LOAD) begin
            check("load_byte", b, e.b);
        end
    endtask

    // Observe outputs mid-cycle; every load/error/overrun must match the next queued event.
    always @(negedge clk) begin
        if (reset) begin
            prev_dv  = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (data_valid) dv_hi_cnt++;
            if (data_valid && (!prev_dv || prev_acc)) begin
                last_load_cyc = cyc;
                got_event(K_LOAD, data);
            end else if (data_valid && prev_dv) begin
                check("data_hold", data, prev_data);
            end
            if (frame_err) got_event(K_FERR, 8'h00);
            if (overrun) got_event(K_OVR, 8'h00);
            prev_dv   = data_valid;
            prev_acc  = data_valid && data_ready;
            prev_data = data;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference outcome of a frame: a bad stop errors, a held byte overruns, else it loads.
    task automatic send_frame(input logic [7:0] b, input int bp, input bit stop_ok);
        ev_t e;
        e.b = b;
        if (!stop_ok) begin
            e.kind = K_FERR;
        end else if (holding && !data_ready) begin
            e.kind = K_OVR;
        end else begin
            e.kind  = K_LOAD;
            holding = !data_ready;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        cycles(bp);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(bp);
        end
        if (stop_ok) begin
            rx = 1'b1;
            cycles(bp);
        end else begin
            rx = 1'b0;
            cycles(bp - 20);
            rx = 1'b1;
            cycles(150);
        end
    endtask

    initial begin
        int c0;
        int n0;
        logic [7:0] rb;
        bit bad;
        int bp;

        cycles(4);
        reset = 1'b0;
        cycles(2);
        check("rst_data", data, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        n0 = dv_hi_cnt;
        c0 = cyc;
        send_frame(8'hA5, BIT, 1'b1);
        cycles(20);
        check_range("a5_latency", last_load_cyc - c0, 1508, 1532);
        check("a5_valid_cycles", dv_hi_cnt - n0, 1);
        check("a5_data", data, 8'hA5);

        rx = 1'b0;
        cycles(40);
        rx = 1'b1;
        cycles(200);
        check("glitch_valid", data_valid, 1'b0);
        send_frame(8'h3C, BIT, 1'b1);
        cycles(20);
        check("after_glitch_data", data, 8'h3C);

        send_frame(8'h81, BIT, 1'b0);
        check("ferr_data_kept", data, 8'h3C);
        check("ferr_valid", data_valid, 1'b0);

        data_ready = 1'b0;
        send_frame(8'h11, BIT, 1'b1);
        send_frame(8'h22, BIT, 1'b1);
        cycles(20);
        check("ovr_valid_held", data_valid, 1'b1);
        check("ovr_data_held", data, 8'h11);
        data_ready = 1'b1;
        cycles(1);
        check("accept_drop", data_valid, 1'b0);
        holding = 1'b0;

        rx = 1'b0;
        cycles(BIT);
        rx = 1'b1;
        cycles(4 * BIT);
        reset = 1'b1;
        cycles(1);
        check("midrst_data", data, 8'h00);
        check("midrst_valid", data_valid, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        reset = 1'b0;
        cycles(2 * BIT);
        check("midrst_no_output", data_valid, 1'b0);
        send_frame(8'h5A, BIT, 1'b1);
        cycles(20);
        check("after_rst_data", data, 8'h5A);

        send_frame(8'h96, 152, 1'b1);
        cycles(20);
        check("skew_fast_data", data, 8'h96);
        send_frame(8'h00, BIT, 1'b1);
        send_frame(8'h96, 168, 1'b1);
        cycles(20);
        check("skew_slow_data", data, 8'h96);

        for (int i = 0; i < 16; i++) begin
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            bp  = bad ? BIT : int'($urandom_range(152, 168));
            send_frame(rb, bp, !bad);
            cycles(int'($urandom_range(0, 60)));
        end

        cycles(400);
        check("events_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
